core_mem_ctrl: RTL and testbench



---
 rtl/core_mem_pkg.sv | 13 +
 rtl/core_mem_ctrl_ring_file.sv | 66 ++++++
 rtl/core_mem_ctrl.sv | 76 +++++++
 tb/tb_core_mem_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and default sizing for the core storage / run-control slice.
package core_mem_pkg;

    localparam int CODE_DEPTH_DEF = 512;
    localparam int CODE_WIDTH_DEF = 16;
    localparam int RING_SLOTS_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;

    typedef logic [CODE_WIDTH_DEF-1:0]          op_t;
    typedef logic [DATA_WIDTH_DEF-1:0]          data_t;
    typedef logic [$clog2(RING_SLOTS_DEF)-1:0]  slot_t;

endpackage

// File: rtl/core_mem_ctrl_ring_file.sv
// Ring register file: one write port, two replicated async-read memories.
// Optional same-cycle write forwarding on slot 0 under CORE_MEM_RING_FWD_EN.
module ring_file
    import core_mem_pkg::*;
#(
    parameter int RING_SLOTS = RING_SLOTS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SLOT_W     = $clog2(RING_SLOTS)
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  running,
    input  logic                  ring_we,
    input  logic [DATA_WIDTH-1:0] ring_wdata,
    input  logic [SLOT_W-1:0]     ring_slot_1,
    input  logic [SLOT_W-1:0]     ring_slot_2,
    output logic [DATA_WIDTH-1:0] ring_rdata_1,
    output logic [DATA_WIDTH-1:0] ring_rdata_2,
    output logic [SLOT_W-1:0]     write_ptr,
    output logic [DATA_WIDTH-1:0] last_data
);

    logic [DATA_WIDTH-1:0] mem_1 [RING_SLOTS];
    logic [DATA_WIDTH-1:0] mem_2 [RING_SLOTS];
    logic [SLOT_W-1:0]     rd_addr_1;
    logic [SLOT_W-1:0]     rd_addr_2;
    logic                  wr_en;

    assign wr_en = ring_we && running;

    // Relative addressing: slot 1 is newest, slot 0 is the next victim.
    assign rd_addr_1 = write_ptr - ring_slot_1;
    assign rd_addr_2 = write_ptr - ring_slot_2;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_1[write_ptr] <= ring_wdata;
            mem_2[write_ptr] <= ring_wdata;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            write_ptr <= '0;
            last_data <= '0;
        end else if (wr_en) begin
            write_ptr <= write_ptr + 1'b1;
            last_data <= ring_wdata;
        end
    end

`ifdef CORE_MEM_RING_FWD_EN
    always_comb begin
        ring_rdata_1 = mem_1[rd_addr_1];
        ring_rdata_2 = mem_2[rd_addr_2];
        if (wr_en && (rd_addr_1 == write_ptr)) ring_rdata_1 = ring_wdata;
        if (wr_en && (rd_addr_2 == write_ptr)) ring_rdata_2 = ring_wdata;
    end
`else
    always_comb begin
        ring_rdata_1 = mem_1[rd_addr_1];
        ring_rdata_2 = mem_2[rd_addr_2];
    end
`endif

endmodule

// File: rtl/core_mem_ctrl.sv
// Code RAM (host r/w port + core fetch port), run flag and ring register file.
// Define CORE_MEM_RING_FWD_EN to forward ring_wdata onto slot-0 reads.
module core_mem_ctrl
    import core_mem_pkg::*;
#(
    parameter int CODE_DEPTH = CODE_DEPTH_DEF,
    parameter int CODE_WIDTH = CODE_WIDTH_DEF,
    parameter int RING_SLOTS = RING_SLOTS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_W     = $clog2(CODE_DEPTH),
    parameter int SLOT_W     = $clog2(RING_SLOTS)
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [CODE_WIDTH-1:0] host_wdata,
    input  logic                  host_we,
    output logic [CODE_WIDTH-1:0] host_rdata,
    input  logic                  run_set,
    input  logic                  run_clr,
    output logic                  running,
    input  logic [ADDR_W-1:0]     code_addr,
    output logic [CODE_WIDTH-1:0] code_rdata,
    input  logic                  ring_we,
    input  logic [DATA_WIDTH-1:0] ring_wdata,
    input  logic [SLOT_W-1:0]     ring_slot_1,
    input  logic [SLOT_W-1:0]     ring_slot_2,
    output logic [DATA_WIDTH-1:0] ring_rdata_1,
    output logic [DATA_WIDTH-1:0] ring_rdata_2,
    output logic [SLOT_W-1:0]     write_ptr,
    output logic [DATA_WIDTH-1:0] last_data
);

    logic [CODE_WIDTH-1:0] code_mem [CODE_DEPTH];

    // Contents survive reset; only the read registers are cleared.
    always_ff @(posedge clock) begin
        if (host_we) code_mem[host_addr] <= host_wdata;
    end

    // Host port is write-first; core port is read-first (sees old data).
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata <= '0;
            code_rdata <= '0;
        end else begin
            host_rdata <= host_we ? host_wdata : code_mem[host_addr];
            code_rdata <= code_mem[code_addr];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)       running <= 1'b0;
        else if (run_clr) running <= 1'b0;
        else if (run_set) running <= 1'b1;
    end

    ring_file #(
        .RING_SLOTS (RING_SLOTS),
        .DATA_WIDTH (DATA_WIDTH),
        .SLOT_W     (SLOT_W)
    ) u_ring_file (
        .clock        (clock),
        .rst_n        (rst_n),
        .running      (running),
        .ring_we      (ring_we),
        .ring_wdata   (ring_wdata),
        .ring_slot_1  (ring_slot_1),
        .ring_slot_2  (ring_slot_2),
        .ring_rdata_1 (ring_rdata_1),
        .ring_rdata_2 (ring_rdata_2),
        .write_ptr    (write_ptr),
        .last_data    (last_data)
    );

endmodule

// File: tb/tb_core_mem_ctrl.sv
// Directed self-checking bench for core_mem_ctrl with hand-computed expectations.
module tb_core_mem_ctrl;

    logic        clock;
    logic        rst_n;
    logic [8:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_we;
    logic [15:0] host_rdata;
    logic        run_set;
    logic        run_clr;
    logic        running;
    logic [8:0]  code_addr;
    logic [15:0] code_rdata;
    logic        ring_we;
    logic [31:0] ring_wdata;
    logic [4:0]  ring_slot_1;
    logic [4:0]  ring_slot_2;
    logic [31:0] ring_rdata_1;
    logic [31:0] ring_rdata_2;
    logic [4:0]  write_ptr;
    logic [31:0] last_data;

    int checks = 0;
    int errors = 0;

    core_mem_ctrl dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_we      (host_we),
        .host_rdata   (host_rdata),
        .run_set      (run_set),
        .run_clr      (run_clr),
        .running      (running),
        .code_addr    (code_addr),
        .code_rdata   (code_rdata),
        .ring_we      (ring_we),
        .ring_wdata   (ring_wdata),
        .ring_slot_1  (ring_slot_1),
        .ring_slot_2  (ring_slot_2),
        .ring_rdata_1 (ring_rdata_1),
        .ring_rdata_2 (ring_rdata_2),
        .write_ptr    (write_ptr),
        .last_data    (last_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        host_addr   = '0;
        host_wdata  = '0;
        host_we     = 1'b0;
        run_set     = 1'b0;
        run_clr     = 1'b0;
        code_addr   = '0;
        ring_we     = 1'b0;
        ring_wdata  = '0;
        ring_slot_1 = 5'd1;
        ring_slot_2 = 5'd2;

        // Reset state
        tick();
        tick();
        check("rst_running", 32'(running), 32'd0);
        check("rst_write_ptr", 32'(write_ptr), 32'd0);
        check("rst_last_data", last_data, 32'd0);
        check("rst_host_rdata", 32'(host_rdata), 32'd0);
        check("rst_code_rdata", 32'(code_rdata), 32'd0);
        rst_n = 1'b1;

        // Host writes 0xBEEF to 5, core reads it back
        host_addr = 9'd5; host_wdata = 16'hBEEF; host_we = 1'b1;
        tick();
        check("host_wr_first_5", 32'(host_rdata), 32'h0000BEEF);
        host_we = 1'b0; code_addr = 9'd5;
        tick();
        check("core_rd_5", 32'(code_rdata), 32'h0000BEEF);

        // Same-address collision at 7: host sees new, core sees old
        host_addr = 9'd7; host_wdata = 16'h1111; host_we = 1'b1;
        tick();
        host_wdata = 16'h1234; code_addr = 9'd7;
        tick();
        check("host_rdw_7", 32'(host_rdata), 32'h00001234);
        check("core_old_7", 32'(code_rdata), 32'h00001111);
        host_we = 1'b0;
        tick();
        check("core_new_7", 32'(code_rdata), 32'h00001234);

        // Start core and write 1,2,3
        check("idle_running", 32'(running), 32'd0);
        run_set = 1'b1;
        tick();
        run_set = 1'b0;
        check("run_set", 32'(running), 32'd1);
        ring_we = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ring_wdata = 32'(i);
            tick();
        end
        ring_we = 1'b0;
        check("ptr_after_3", 32'(write_ptr), 32'd3);
        check("last_after_3", last_data, 32'd3);
        check("slot1_3", ring_rdata_1, 32'd3);
        check("slot2_2", ring_rdata_2, 32'd2);
        ring_slot_1 = 5'd3;
        #1;
        check("slot3_1", ring_rdata_1, 32'd1);
        ring_slot_1 = 5'd1;

        // Stop; writes while stopped are ignored
        run_clr = 1'b1;
        tick();
        run_clr = 1'b0;
        check("run_clr", 32'(running), 32'd0);
        ring_we = 1'b1; ring_wdata = 32'd99;
        tick();
        ring_we = 1'b0;
        check("stopped_ptr", 32'(write_ptr), 32'd3);
        check("stopped_last", last_data, 32'd3);
        check("stopped_slot1", ring_rdata_1, 32'd3);

        // Set and clear together: clear wins
        run_set = 1'b1;
        tick();
        check("run_set_again", 32'(running), 32'd1);
        run_clr = 1'b1;
        tick();
        run_set = 1'b0; run_clr = 1'b0;
        check("set_clr_both", 32'(running), 32'd0);

        // Reset mid-run
        run_set = 1'b1;
        tick();
        run_set = 1'b0;
        ring_we = 1'b1; ring_wdata = 32'd7;
        tick();
        ring_we = 1'b0;
        check("pre_rst_ptr", 32'(write_ptr), 32'd4);
        check("pre_rst_last", last_data, 32'd7);
        rst_n = 1'b0;
        #1;
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_ptr", 32'(write_ptr), 32'd0);
        check("async_rst_last", last_data, 32'd0);
        tick();
        rst_n = 1'b1;
        code_addr = 9'd5; host_addr = 9'd7;
        tick();
        check("keep_core_5", 32'(code_rdata), 32'h0000BEEF);
        check("keep_host_7", 32'(host_rdata), 32'h00001234);

        // 33 writes of 0..32 wrap the pointer
        run_set = 1'b1;
        tick();
        run_set = 1'b0;
        ring_we = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            ring_wdata = 32'(i);
            tick();
        end
        ring_we = 1'b0;
        ring_slot_1 = 5'd1; ring_slot_2 = 5'd0;
        #1;
        check("wrap_ptr", 32'(write_ptr), 32'd1);
        check("wrap_last", last_data, 32'd32);
        check("wrap_slot1", ring_rdata_1, 32'd32);
        check("wrap_slot32", ring_rdata_2, 32'd1);
        ring_slot_1 = 5'd31;
        #1;
        check("wrap_slot31", ring_rdata_1, 32'd2);

        // Slot 0 during a write: forwarded or stale
        ring_slot_1 = 5'd0; ring_slot_2 = 5'd1;
        ring_we = 1'b1; ring_wdata = 32'h55;
        #1;
`ifdef CORE_MEM_RING_FWD_EN
        check("slot0_fwd", ring_rdata_1, 32'h55);
`else
        check("slot0_stale", ring_rdata_1, 32'd1);
`endif
        check("slot1_during_wr", ring_rdata_2, 32'd32);
        tick();
        ring_we = 1'b0;
        check("post_fwd_ptr", 32'(write_ptr), 32'd2);
        check("post_fwd_slot1", ring_rdata_2, 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
